alu_writeback_queue: RTL and testbench

//  Consumer end of the ALU result path. Accepts 16-bit results (OR/AND/ADD...) plus

---
 rtl/alu_writeback_queue.sv | 199 +++++++++++++++++++
 tb/tb_alu_writeback_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_queue.sv
// -----------------------------------------------------------------------------
// alu_writeback_queue
//
// Purpose
//   Consumer end of the ALU result path. ALU results (with their destination
//   register) arrive over a valid/ready handshake and are held in a small
//   circular FIFO. The head entry is written to the register file in any cycle
//   where the write-port arbiter grants this block. A combinational forwarding
//   lookup searches all pending entries so decode can bypass results that have
//   not yet been written back. When several pending entries target the same
//   register, the youngest one wins.
//
// Parameters
//   DATA_W  result width
//   ADDR_W  register address width
//   DEPTH   FIFO entries. Must be a power of two and at least 2.
//
// Ports
//   CLK          in   rising-edge clock
//   RST          in   synchronous, active-high reset
//   IN_VALID     in   ALU result valid
//   IN_READY     out  queue can accept a result this cycle
//   RESULT       in   ALU result data
//   DEST         in   destination register
//   WB_GRANT     in   register-file write port granted this cycle
//   WE           out  register-file write enable
//   WADDR        out  register-file write address (0 when the queue is empty)
//   WDATA        out  register-file write data (0 when the queue is empty)
//   LOOKUP_ADDR  in   forwarding query address
//   FWD_HIT      out  a pending entry targets LOOKUP_ADDR
//   FWD_DATA     out  data of the youngest matching pending entry (0 on miss)
//   OCC          out  current entry count
//
// Build option
//   WB_ZERO_DISCARD_EN  When defined, results addressed to register 0 complete
//                       the handshake but are dropped. They are never stored,
//                       never written and never forwarded, and a lookup of
//                       register 0 always misses. When undefined, register 0
//                       is handled like any other register.
// -----------------------------------------------------------------------------
module alu_writeback_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [DATA_W-1:0]         RESULT,
  input  logic [ADDR_W-1:0]         DEST,
  input  logic                      WB_GRANT,
  output logic                      WE,
  output logic [ADDR_W-1:0]         WADDR,
  output logic [DATA_W-1:0]         WDATA,
  input  logic [ADDR_W-1:0]         LOOKUP_ADDR,
  output logic                      FWD_HIT,
  output logic [DATA_W-1:0]         FWD_DATA,
  output logic [$clog2(DEPTH):0]    OCC
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Entry storage is never reset. Valid entries are defined by head/count.
  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake and pop control
  // ---------------------------------------------------------------------------
  logic push;       // handshake completes this cycle
  logic store;      // the accepted result actually occupies an entry
  logic pop;        // head entry is written back this cycle
  logic not_empty;

  assign not_empty = (count_q != '0);

  // Readiness depends only on state and reset, never on IN_VALID.
  // A full queue stays not-ready even when it pops in the same cycle.
  assign IN_READY = !RST && (count_q < CNT_W'(DEPTH));
  assign push     = IN_VALID && IN_READY;

`ifdef WB_ZERO_DISCARD_EN
  assign store = push && (DEST != '0);
`else
  assign store = push;
`endif

  assign WE  = !RST && not_empty && WB_GRANT;
  assign pop = WE;

  // The write port shows the head entry whenever one exists. It stays stable
  // while the grant is withheld.
  assign WADDR = not_empty ? dest_q[head_q] : '0;
  assign WDATA = not_empty ? data_q[head_q] : '0;
  assign OCC   = count_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (store) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry write. No reset: after a reset, stale contents are unreachable
  // because count is zero.
  always_ff @(posedge CLK) begin
    if (store) begin
      dest_q[tail_q] <= DEST;
      data_q[tail_q] <= RESULT;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding lookup
  //
  // Age of a slot is its distance from head. Age 0 is the oldest entry and
  // age count-1 is the youngest. A slot holds a pending entry when its age is
  // below count. The entry popped this cycle is still pending, because the
  // register file only takes the write at the next edge. An entry being
  // pushed this cycle is not yet visible.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] age   [DEPTH];
  logic [DEPTH-1:0] match;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Modular subtraction over PTR_W bits handles pointer wrap.
    assign age[gi]   = PTR_W'(gi) - head_q;
    assign match[gi] = ({1'b0, age[gi]} < count_q) && (dest_q[gi] == LOOKUP_ADDR);
  end

  logic             fwd_hit_raw;
  logic [DATA_W-1:0] fwd_data_raw;
  logic [PTR_W-1:0] best_age;

  always_comb begin
    fwd_hit_raw  = 1'b0;
    fwd_data_raw = '0;
    best_age     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Ages are unique, so keeping the largest age selects the youngest match.
      if (match[i] && (!fwd_hit_raw || (age[i] > best_age))) begin
        fwd_hit_raw  = 1'b1;
        best_age     = age[i];
        fwd_data_raw = data_q[i];
      end
    end
  end

  always_comb begin
    FWD_HIT  = fwd_hit_raw;
    FWD_DATA = fwd_data_raw;
    if (RST) begin
      FWD_HIT  = 1'b0;
      FWD_DATA = '0;
    end
`ifdef WB_ZERO_DISCARD_EN
    // Register 0 is never held, so a lookup of it always misses.
    if (LOOKUP_ADDR == '0) begin
      FWD_HIT  = 1'b0;
      FWD_DATA = '0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_writeback_queue.sv
module tb_alu_writeback_queue;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;

  logic              CLK;
  logic              RST;
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] RESULT;
  logic [ADDR_W-1:0] DEST;
  logic              WB_GRANT;
  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [DATA_W-1:0] WDATA;
  logic [ADDR_W-1:0] LOOKUP_ADDR;
  logic              FWD_HIT;
  logic [DATA_W-1:0] FWD_DATA;
  logic [$clog2(DEPTH):0] OCC;

  int checks_cnt;
  int errors_cnt;

  alu_writeback_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .RESULT      (RESULT),
    .DEST        (DEST),
    .WB_GRANT    (WB_GRANT),
    .WE          (WE),
    .WADDR       (WADDR),
    .WDATA       (WDATA),
    .LOOKUP_ADDR (LOOKUP_ADDR),
    .FWD_HIT     (FWD_HIT),
    .FWD_DATA    (FWD_DATA),
    .OCC         (OCC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock edge. Inputs change 1 time unit after the edge, and
  // checks run 1 time unit later, well away from the next edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Scoreboard for the wrap test.
  logic [ADDR_W-1:0] exp_dest [$];
  logic [DATA_W-1:0] exp_data [$];

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    RST         = 1'b1;
    IN_VALID    = 1'b1;
    RESULT      = 16'h1234;
    DEST        = 3'd2;
    WB_GRANT    = 1'b1;
    LOOKUP_ADDR = 3'd2;

    // T1: reset held two cycles with IN_VALID high.
    for (int c = 0; c < 2; c++) begin
      step();
      check_val("t1_in_ready", 32'(IN_READY), 32'h0);
      check_val("t1_we",       32'(WE),       32'h0);
      check_val("t1_occ",      32'(OCC),      32'h0);
      check_val("t1_fwd_hit",  32'(FWD_HIT),  32'h0);
    end
    RST      = 1'b0;
    IN_VALID = 1'b0;
    settle();
    check_val("t1_occ_after", 32'(OCC), 32'h0);
    check_val("t1_ready_after", 32'(IN_READY), 32'h1);

    // T2: single result, granted. No pass-through in the push cycle.
    IN_VALID = 1'b1; RESULT = 16'h00F3; DEST = 3'd3; WB_GRANT = 1'b1;
    settle();
    check_val("t2_ready", 32'(IN_READY), 32'h1);
    check_val("t2_no_pass", 32'(WE), 32'h0);
    check_val("t2_waddr_empty", 32'(WADDR), 32'h0);
    step();
    IN_VALID = 1'b0;
    settle();
    check_val("t2_we",    32'(WE),    32'h1);
    check_val("t2_waddr", 32'(WADDR), 32'h3);
    check_val("t2_wdata", 32'(WDATA), 32'h00F3);
    check_val("t2_occ1",  32'(OCC),   32'h1);
    step();
    check_val("t2_occ0",  32'(OCC),   32'h0);
    check_val("t2_we_off", 32'(WE),   32'h0);
    check_val("t2_wdata_empty", 32'(WDATA), 32'h0);

    // T3: backpressure.
    WB_GRANT = 1'b0;
    IN_VALID = 1'b1; RESULT = 16'hA5A5; DEST = 3'd1;
    settle();
    check_val("t3_ready0", 32'(IN_READY), 32'h1);
    step();
    RESULT = 16'h5A5A; DEST = 3'd2;
    settle();
    check_val("t3_ready1", 32'(IN_READY), 32'h1);
    check_val("t3_occ1",   32'(OCC),      32'h1);
    step();
    RESULT = 16'hC3C3; DEST = 3'd6;
    settle();
    check_val("t3_full_ready", 32'(IN_READY), 32'h0);
    check_val("t3_full_occ",   32'(OCC),      32'h2);
    check_val("t3_hold_we",    32'(WE),       32'h0);
    check_val("t3_hold_waddr", 32'(WADDR),    32'h1);
    check_val("t3_hold_wdata", 32'(WDATA),    32'hA5A5);
    step();
    check_val("t3_still_full", 32'(OCC), 32'h2);
    check_val("t3_still_ready", 32'(IN_READY), 32'h0);
    WB_GRANT = 1'b1;
    settle();
    check_val("t3_pop_we",    32'(WE),       32'h1);
    check_val("t3_pop_waddr", 32'(WADDR),    32'h1);
    check_val("t3_pop_wdata", 32'(WDATA),    32'hA5A5);
    check_val("t3_no_refill", 32'(IN_READY), 32'h0);
    step();
    WB_GRANT = 1'b0;
    settle();
    check_val("t3_after_occ",   32'(OCC),      32'h1);
    check_val("t3_after_ready", 32'(IN_READY), 32'h1);
    check_val("t3_head2_waddr", 32'(WADDR),    32'h2);
    check_val("t3_head2_wdata", 32'(WDATA),    32'h5A5A);
    step();
    IN_VALID = 1'b0; WB_GRANT = 1'b1;
    settle();
    check_val("t3_third_in_occ", 32'(OCC),   32'h2);
    check_val("t3_d1_waddr",     32'(WADDR), 32'h2);
    check_val("t3_d1_wdata",     32'(WDATA), 32'h5A5A);
    step();
    check_val("t3_d2_waddr", 32'(WADDR), 32'h6);
    check_val("t3_d2_wdata", 32'(WDATA), 32'hC3C3);
    check_val("t3_d2_occ",   32'(OCC),   32'h1);
    step();
    check_val("t3_empty", 32'(OCC), 32'h0);

    // T4: forwarding, youngest wins.
    WB_GRANT = 1'b0; LOOKUP_ADDR = 3'd4;
    IN_VALID = 1'b1; RESULT = 16'h1111; DEST = 3'd4;
    settle();
    check_val("t4_push_invisible", 32'(FWD_HIT), 32'h0);
    step();
    RESULT = 16'h2222; DEST = 3'd4;
    settle();
    check_val("t4_first_hit",  32'(FWD_HIT),  32'h1);
    check_val("t4_first_data", 32'(FWD_DATA), 32'h1111);
    step();
    IN_VALID = 1'b0;
    settle();
    check_val("t4_young_hit",  32'(FWD_HIT),  32'h1);
    check_val("t4_young_data", 32'(FWD_DATA), 32'h2222);
    LOOKUP_ADDR = 3'd5;
    settle();
    check_val("t4_miss_hit",  32'(FWD_HIT),  32'h0);
    check_val("t4_miss_data", 32'(FWD_DATA), 32'h0);
    LOOKUP_ADDR = 3'd4; WB_GRANT = 1'b1;
    settle();
    check_val("t4_dr1_wdata", 32'(WDATA),    32'h1111);
    check_val("t4_dr1_waddr", 32'(WADDR),    32'h4);
    check_val("t4_dr1_fwd",   32'(FWD_DATA), 32'h2222);
    step();
    check_val("t4_dr2_wdata", 32'(WDATA),    32'h2222);
    check_val("t4_dr2_we",    32'(WE),       32'h1);
    check_val("t4_popping_hit",  32'(FWD_HIT),  32'h1);
    check_val("t4_popping_data", 32'(FWD_DATA), 32'h2222);
    step();
    check_val("t4_empty_occ", 32'(OCC),     32'h0);
    check_val("t4_empty_hit", 32'(FWD_HIT), 32'h0);

    // T5: ten back-to-back pushes with the grant held, across pointer wrap.
    begin
      int pushed;
      int written;
      int cyc;
      pushed  = 0;
      written = 0;
      cyc     = 0;
      WB_GRANT = 1'b1;
      while ((pushed < 10 || written < 10) && cyc < 60) begin
        IN_VALID = (pushed < 10);
        RESULT   = 16'h0100 + 16'(pushed);
        DEST     = 3'((pushed % 7) + 1);
        settle();
        if (OCC > 2'(DEPTH)) check_val("t5_occ_bound", 32'(OCC), 32'(DEPTH));
        if (WE) begin
          if (exp_data.size() == 0) begin
            check_val("t5_spurious_we", 32'(WE), 32'h0);
          end else begin
            check_val($sformatf("t5_waddr_%0d", written), 32'(WADDR), 32'(exp_dest[0]));
            check_val($sformatf("t5_wdata_%0d", written), 32'(WDATA), 32'(exp_data[0]));
            void'(exp_dest.pop_front());
            void'(exp_data.pop_front());
          end
          written++;
        end
        if (IN_VALID && IN_READY) begin
          exp_dest.push_back(DEST);
          exp_data.push_back(RESULT);
          pushed++;
        end
        step();
        cyc++;
      end
      IN_VALID = 1'b0;
      check_val("t5_pushed",  32'(pushed),  32'd10);
      check_val("t5_written", 32'(written), 32'd10);
      check_val("t5_cycles_back_to_back", 32'(cyc), 32'd11);
      settle();
      check_val("t5_end_occ", 32'(OCC), 32'h0);
    end

    // T6: destination register 0.
    WB_GRANT = 1'b1; LOOKUP_ADDR = 3'd0;
    IN_VALID = 1'b1; RESULT = 16'hDEAD; DEST = 3'd0;
    settle();
    check_val("t6_ready", 32'(IN_READY), 32'h1);
    step();
    IN_VALID = 1'b0;
    settle();
`ifdef WB_ZERO_DISCARD_EN
    check_val("t6_we",      32'(WE),      32'h0);
    check_val("t6_occ",     32'(OCC),     32'h0);
    check_val("t6_fwd_hit", 32'(FWD_HIT), 32'h0);
`else
    check_val("t6_we",       32'(WE),       32'h1);
    check_val("t6_waddr",    32'(WADDR),    32'h0);
    check_val("t6_wdata",    32'(WDATA),    32'hDEAD);
    check_val("t6_fwd_hit",  32'(FWD_HIT),  32'h1);
    check_val("t6_fwd_data", 32'(FWD_DATA), 32'hDEAD);
`endif
    step();
    check_val("t6_empty", 32'(OCC), 32'h0);

    // Reset while entries are pending drops all of them.
    WB_GRANT = 1'b0; LOOKUP_ADDR = 3'd5;
    IN_VALID = 1'b1; RESULT = 16'h7777; DEST = 3'd5;
    step();
    RESULT = 16'h8888; DEST = 3'd6;
    step();
    IN_VALID = 1'b0;
    settle();
    check_val("t6_pre_rst_occ", 32'(OCC),     32'h2);
    check_val("t6_pre_rst_hit", 32'(FWD_HIT), 32'h1);
    RST = 1'b1; WB_GRANT = 1'b1;
    settle();
    check_val("t6_rst_ready", 32'(IN_READY), 32'h0);
    check_val("t6_rst_we",    32'(WE),       32'h0);
    check_val("t6_rst_hit",   32'(FWD_HIT),  32'h0);
    step();
    RST = 1'b0;
    settle();
    check_val("t6_post_occ", 32'(OCC),     32'h0);
    check_val("t6_post_we",  32'(WE),      32'h0);
    check_val("t6_post_hit", 32'(FWD_HIT), 32'h0);
    step();
    check_val("t6_post_we2", 32'(WE), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
